// File: rtl/led_pattern_engine_if.sv
// Board-side bundle for led_pattern_engine: switches/buttons in, LED banks out.
interface led_pattern_engine_if #(
  parameter int N_LEDS = 4,
  parameter int NB_SW  = 4,
  parameter int NB_BTN = 4
);
  logic [NB_SW-1:0]  i_sw;
  logic [NB_BTN-1:0] i_btn;
  logic [N_LEDS-1:0] o_led;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;
  logic [1:0]        o_mode;
  logic              o_tick;

  // board pins (or a bench) drive the switches and buttons
  modport master (output i_sw, i_btn,
                  input  o_led, o_led_r, o_led_g, o_led_b, o_mode, o_tick);
  // the engine consumes switches/buttons and drives the LEDs
  modport slave  (input  i_sw, i_btn,
                  output o_led, o_led_r, o_led_g, o_led_b, o_mode, o_tick);
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaled pattern generator (shift/flash/ping-pong/binary)
// with synchronised, edge-detected buttons and colour-gated RGB banks.

// One button lane: 2-flop synchroniser plus previous-value edge detect.
module lpe_btn_sync (
  input  logic clock,
  input  logic ck_rst,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, prev;

  // metastability chain; prev lets a held button fire only once
  always_ff @(posedge clock) begin
    if (!ck_rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;
endmodule

module led_pattern_engine #(
  parameter int N_LEDS   = 4,
  parameter int NB_SEL   = 2,
  parameter int NB_COUNT = 14,
  parameter int NB_SW    = 4,
  parameter int NB_BTN   = 4
) (
  input logic            clock,
  input logic            ck_rst,
  led_pattern_engine_if.slave bus
);
  typedef enum logic [1:0] {M_SHIFT, M_FLASH, M_PING, M_BIN} mode_t;

  localparam logic [NB_COUNT-1:0] TOP = NB_COUNT'(1) << (NB_COUNT-1);
  localparam logic [N_LEDS-1:0]   ONE = N_LEDS'(1);

  logic [NB_SW-1:0]    sw;
  logic                en, dir;
  logic [NB_SEL-1:0]   sel;
  logic [NB_COUNT-1:0] limit;
  logic [NB_BTN-1:0]   pulse;

  mode_t               mode_q, mode_d;
  logic [N_LEDS-1:0]   pat_q, pat_d, nxt;
  logic                up_q, up_d, nxt_up;
  logic [2:0]          col_q, col_d;   // one-hot {b,g,r}
  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;

  assign sw    = bus.i_sw;
  assign en    = sw[0];
  assign sel   = sw[NB_SEL:1];
  assign dir   = sw[NB_SEL+1];
  // 2^(NB_COUNT-1-sel) - 1 without a variable subtraction in the exponent
  assign limit = (TOP >> sel) - NB_COUNT'(1);

  genvar gb;
  generate
    for (gb = 0; gb < NB_BTN; gb++) begin : g_btn
      lpe_btn_sync u_sync (
        .clock (clock),
        .ck_rst(ck_rst),
        .btn   (bus.i_btn[gb]),
        .pulse (pulse[gb])
      );
    end
  endgenerate

  // state registers
  always_ff @(posedge clock) begin
    if (!ck_rst) begin
      mode_q <= M_SHIFT;
      pat_q  <= ONE;
      up_q   <= 1'b1;
      col_q  <= 3'b001;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
      up_q   <= up_d;
      col_q  <= col_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // next pattern for one step of the current mode
  always_comb begin
    nxt    = pat_q;
    nxt_up = up_q;
    case (mode_q)
      M_SHIFT: nxt = dir ? {pat_q[0], pat_q[N_LEDS-1:1]}
                         : {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
      M_FLASH: nxt = ~pat_q;
      M_PING: begin
        nxt = up_q ? (pat_q << 1) : (pat_q >> 1);
        if (nxt[N_LEDS-1])  nxt_up = 1'b0;
        else if (nxt[0])    nxt_up = 1'b1;
      end
      default: nxt = pat_q + ONE;
    endcase
  end

  // prescaler, mode advance (overrides a same-cycle step) and colour select
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    up_d   = up_q;
    col_d  = col_q;
    cnt_d  = cnt_q;
    tick_d = en && (cnt_q >= limit);

    if (tick_d) begin
      cnt_d = '0;
      pat_d = nxt;
      up_d  = nxt_up;
    end else if (en) begin
      cnt_d = cnt_q + NB_COUNT'(1);
    end

    if (pulse[0]) begin
      mode_d = mode_t'(mode_q + 2'd1);
      cnt_d  = '0;
      up_d   = 1'b1;
      case (mode_d)
        M_FLASH: pat_d = '1;
        M_BIN:   pat_d = '0;
        default: pat_d = ONE;
      endcase
    end

    if (pulse[1])      col_d = 3'b001;
    else if (pulse[2]) col_d = 3'b010;
    else if (pulse[3]) col_d = 3'b100;
  end

  assign bus.o_led   = pat_q;
  assign bus.o_led_r = pat_q & {N_LEDS{col_q[0]}};
  assign bus.o_led_g = pat_q & {N_LEDS{col_q[1]}};
  assign bus.o_led_b = pat_q & {N_LEDS{col_q[2]}};
  assign bus.o_mode  = mode_q;
  assign bus.o_tick  = tick_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with NB_COUNT=6 (sel 0..3 = 32/16/8/4 cycles).
module tb_led_pattern_engine;
  logic clock = 1'b0;
  logic ck_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ticks_seen;

  led_pattern_engine_if #(.N_LEDS(4), .NB_SW(4), .NB_BTN(4)) bus ();

  led_pattern_engine #(
    .N_LEDS(4), .NB_SEL(2), .NB_COUNT(6), .NB_SW(4), .NB_BTN(4)
  ) dut (
    .clock (clock),
    .ck_rst(ck_rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b);
    chk({tag, "_r"}, {28'd0, bus.o_led_r}, {28'd0, r});
    chk({tag, "_g"}, {28'd0, bus.o_led_g}, {28'd0, g});
    chk({tag, "_b"}, {28'd0, bus.o_led_b}, {28'd0, b});
  endtask

  task automatic chk_led(input string tag, input logic [3:0] led, input logic tk);
    chk({tag, "_led"},  {28'd0, bus.o_led}, {28'd0, led});
    chk({tag, "_tick"}, {31'd0, bus.o_tick}, {31'd0, tk});
  endtask

  initial begin
    // sw = {dir, sel[1:0], en}
    ck_rst     = 1'b0;
    bus.i_sw   = 4'b0111;
    bus.i_btn  = 4'b0000;
    edges(2);
    chk_led("rst", 4'b0001, 1'b0);
    chk_rgb("rst", 4'b0001, 4'b0000, 4'b0000);
    chk("rst_mode", {30'd0, bus.o_mode}, 32'd0);

    // SHIFT toward MSB at 4-cycle period
    ck_rst = 1'b1;
    edges(3); chk_led("sh0", 4'b0001, 1'b0);
    edges(1); chk_led("sh1", 4'b0010, 1'b1);
    chk_rgb("sh1", 4'b0010, 4'b0000, 4'b0000);
    edges(1); chk("sh1_tick_off", {31'd0, bus.o_tick}, 32'd0);
    edges(3); chk_led("sh2", 4'b0100, 1'b1);
    edges(4); chk_led("sh3", 4'b1000, 1'b1);
    edges(4); chk_led("sh4", 4'b0001, 1'b1);
    edges(4); chk_led("sh5", 4'b0010, 1'b1);
    edges(4); chk_led("sh6", 4'b0100, 1'b1);

    // direction flipped live at 0100
    bus.i_sw = 4'b1111;
    edges(4); chk_led("dir", 4'b0010, 1'b1);

    // freeze with count at 2
    edges(2);
    bus.i_sw = 4'b1110;
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      if (bus.o_tick) ticks_seen++;
    end
    chk("hold_ticks", ticks_seen, 0);
    chk("hold_led", {28'd0, bus.o_led}, 32'h2);
    bus.i_sw = 4'b1111;
    edges(1); chk_led("resume0", 4'b0010, 1'b0);
    edges(1); chk_led("resume1", 4'b0001, 1'b1);

    // btn[0] held 50 cycles: one advance to FLASH, counter restarts
    bus.i_btn = 4'b0001;
    edges(2); chk("flash_pre", {30'd0, bus.o_mode}, 32'd0);
    edges(1); chk("flash_mode", {30'd0, bus.o_mode}, 32'd1);
    chk_led("flash0", 4'b1111, 1'b0);
    edges(3); chk_led("flash1", 4'b1111, 1'b0);
    edges(1); chk_led("flash2", 4'b0000, 1'b1);
    edges(43);
    chk("held_mode", {30'd0, bus.o_mode}, 32'd1);
    chk("held_led", {28'd0, bus.o_led}, 32'h0);
    bus.i_btn = 4'b0000;
    edges(1); chk_led("flash3", 4'b1111, 1'b1);

    // PINGPONG
    bus.i_btn = 4'b0001;
    edges(3); bus.i_btn = 4'b0000;
    chk("pp_mode", {30'd0, bus.o_mode}, 32'd2);
    chk_led("pp0", 4'b0001, 1'b0);
    edges(4); chk_led("pp1", 4'b0010, 1'b1);
    edges(4); chk_led("pp2", 4'b0100, 1'b1);
    edges(4); chk_led("pp3", 4'b1000, 1'b1);
    edges(4); chk_led("pp4", 4'b0100, 1'b1);
    edges(4); chk_led("pp5", 4'b0010, 1'b1);
    edges(4); chk_led("pp6", 4'b0001, 1'b1);
    edges(4); chk_led("pp7", 4'b0010, 1'b1);

    // BINARY counts through and wraps
    bus.i_btn = 4'b0001;
    edges(3); bus.i_btn = 4'b0000;
    chk("bin_mode", {30'd0, bus.o_mode}, 32'd3);
    chk_led("bin0", 4'b0000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      edges(4);
      chk("bin_led", {28'd0, bus.o_led}, {28'd0, 4'(i)});
    end

    // back to SHIFT (dir still toward LSB); green requested at once
    bus.i_btn = 4'b0001;
    edges(3);
    chk("shift_mode", {30'd0, bus.o_mode}, 32'd0);
    chk_led("shift_back", 4'b0001, 1'b0);
    bus.i_btn = 4'b0100;
    edges(3); chk_rgb("green", 4'b0000, 4'b0001, 4'b0000);
    edges(1); chk_rgb("green_step", 4'b0000, 4'b1000, 4'b0000);
    bus.i_btn = 4'b1010;
    edges(3); chk_rgb("r_and_b", 4'b1000, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    edges(1);
    bus.i_btn = 4'b0010;
    edges(3); chk_rgb("red_again", 4'b0100, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    edges(1);
    bus.i_btn = 4'b1000;
    edges(3); chk_rgb("blue", 4'b0000, 4'b0000, 4'b0010);
    bus.i_btn = 4'b0000;

    // sel 0 until count reaches 20, then sel 3 ticks on the next edge
    bus.i_sw = 4'b1001;
    ticks_seen = 0;
    for (int i = 0; i < 17; i++) begin
      edges(1);
      if (bus.o_tick) ticks_seen++;
    end
    chk("sel0_ticks", ticks_seen, 0);
    bus.i_sw = 4'b1111;
    edges(1); chk_led("sel_change", 4'b0001, 1'b1);

    // reset mid-FLASH
    bus.i_btn = 4'b0001;
    edges(3); bus.i_btn = 4'b0000;
    chk_led("flash_again", 4'b1111, 1'b0);
    edges(2);
    ck_rst = 1'b0;
    edges(1);
    chk_led("rst2", 4'b0001, 1'b0);
    chk_rgb("rst2", 4'b0001, 4'b0000, 4'b0000);
    chk("rst2_mode", {30'd0, bus.o_mode}, 32'd0);
    ck_rst = 1'b1;
    edges(3); chk_led("post_rst0", 4'b0001, 1'b0);
    edges(1); chk_led("post_rst1", 4'b1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
